// File: rtl/aes_inv_cipher_if.sv
// Bus bundle for the AES-128 inverse cipher: load strobe, key and
// ciphertext in; plaintext, completion pulse, busy flag and FSM state out.
interface aes_inv_cipher_if;
    logic         ld;
    logic [127:0] key;
    logic [127:0] text_in;
    logic         done;
    logic [127:0] text_out;
    logic         busy;
    logic [1:0]   fsm_state;

    // Handshake: ld is a request that is taken only while the core is idle
    // (busy=0). Once taken, busy stays high until the result is written;
    // done then pulses for one cycle and text_out holds that result until
    // the next completed operation or reset.
    modport master (
        output ld, key, text_in,
        input  done, text_out, busy, fsm_state
    );

    modport slave (
        input  ld, key, text_in,
        output done, text_out, busy, fsm_state
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher, one round per clock. The round key is expanded
// forward to round 10 in KEXP, then walked backward one step per round in
// DEC, so only a single 128-bit round-key register is needed.
module aes_inv_cipher (
    input logic              clk,
    input logic              rst,
    aes_inv_cipher_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] KEXP = 2'd1;
    localparam logic [1:0] DEC  = 2'd2;

    logic [1:0]   fsm;
    logic [3:0]   rcnt;
    logic [127:0] rk;
    logic [127:0] ct;
    logic [127:0] sa;
    logic [127:0] text_out_q;
    logic         done_q;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] p;
        s = gf_mul(a, a);
        p = s;
        for (int i = 0; i < 6; i++) begin
            s = gf_mul(s, s);
            p = gf_mul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Key schedule: the four S-boxes serve both directions. Going forward
    // they see the current w3; going backward they need the previous key's
    // w3, which is w3' ^ w2'.
    logic [31:0]  w0, w1, w2, w3, prev_w3, sub_in, rot, sub_word, t_word;
    logic [127:0] rk_fwd, rk_inv;

    always_comb begin
        {w0, w1, w2, w3} = rk;
        prev_w3  = w3 ^ w2;
        sub_in   = (fsm == KEXP) ? w3 : prev_w3;
        rot      = {sub_in[23:0], sub_in[31:24]};
        sub_word = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t_word   = sub_word ^ {rcon(rcnt), 24'h000000};
        rk_fwd[127:96] = w0 ^ t_word;
        rk_fwd[95:64]  = w1 ^ rk_fwd[127:96];
        rk_fwd[63:32]  = w2 ^ rk_fwd[95:64];
        rk_fwd[31:0]   = w3 ^ rk_fwd[63:32];
        rk_inv = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, prev_w3};
    end

    // Round datapath: InvShiftRows + InvSubBytes, AddRoundKey, InvMixColumns
    logic [127:0] isb, ark, mix;

    always_comb begin
        isb = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isb[127 - 8 * (r + 4 * c) -: 8] =
                    inv_sbox(sa[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8]);
            end
        end
        ark = isb ^ rk;
        for (int c = 0; c < 4; c++) begin
            mix[127 - 32 * c -: 32] = inv_mix_col(ark[127 - 32 * c -: 32]);
        end
    end

    // Control FSM and datapath registers. In DEC, rcnt=10 marks the
    // initial AddRoundKey; 9..1 are full rounds; 0 is the final round.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            rcnt       <= 4'd0;
            rk         <= '0;
            ct         <= '0;
            sa         <= '0;
            text_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (bus.ld) begin
                        rk   <= bus.key;
                        ct   <= bus.text_in;
                        rcnt <= 4'd1;
                        fsm  <= KEXP;
                    end
                end
                KEXP: begin
                    rk <= rk_fwd;
                    if (rcnt == 4'd10) fsm <= DEC;
                    else               rcnt <= rcnt + 4'd1;
                end
                DEC: begin
                    if (rcnt == 4'd10) begin
                        sa   <= ct ^ rk;
                        rk   <= rk_inv;
                        rcnt <= 4'd9;
                    end else if (rcnt == 4'd0) begin
                        sa         <= ark;
                        text_out_q <= ark;
                        done_q     <= 1'b1;
                        fsm        <= IDLE;
                    end else begin
                        sa   <= mix;
                        rk   <= rk_inv;
                        rcnt <= rcnt - 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.text_out  = text_out_q;
    assign bus.busy      = (fsm != IDLE);
    assign bus.fsm_state = fsm;
endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
- REQ-001: The block SHALL have no parameters; all widths are fixed for AES-128.
- REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: ld  input  1  start strobe; SHALL be sampled only in IDLE.
- REQ-005: key  input  128  cipher key; key[127:120] is the first key byte.
- REQ-006: text_in  input  128  ciphertext; text_in[127:120] = state byte sa00, column-major (sa00, sa10, sa20, sa30, sa01, ...).
- REQ-007: done  output  1  one-cycle pulse; text_out is valid from that cycle.
- REQ-008: text_out  output  128  plaintext, same byte order as text_in.
- REQ-009: busy  output  1  high while in KEXP or DEC.

Function
- REQ-010: The block SHALL implement the FIPS-197 AES-128 inverse cipher, computing one round per clock.
- REQ-011: The FSM SHALL have states IDLE, KEXP and DEC; reset SHALL enter IDLE.
- REQ-012: In IDLE with ld=1, the block SHALL:
  - capture key into the round-key register;
  - capture text_in into the ciphertext register;
  - clear the round counter rcnt to 1;
  - go to KEXP.
- REQ-013: In KEXP, each cycle SHALL compute the forward round key rcnt from the current round key:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[rcnt];
  - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- REQ-014: Rcon SHALL be 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36 in the top byte, for rounds 1..10.
- REQ-015: After the edge producing round key 10, the FSM SHALL go to DEC.
  - On the first DEC edge, state SHALL load ciphertext ^ rk10.
  - rcnt SHALL be set to 9.
- REQ-016: On each DEC edge for rcnt = 9..1, state SHALL become InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rcnt]).
- REQ-017: On the DEC edge for rcnt = 0, state SHALL become InvSubBytes(InvShiftRows(state)) ^ rk0, with no InvMixColumns; the FSM SHALL then return to IDLE.
- REQ-018: The round key SHALL be walked backward in step with the rounds using the inverse schedule:
  - w3 = w3' ^ w2'; w2 = w2' ^ w1'; w1 = w1' ^ w0';
  - w0 = w0' ^ SubWord(RotWord(w3)) ^ Rcon[r].
- REQ-019: Round keys SHALL NOT be stored in a table; only one 128-bit round-key register SHALL exist.
- REQ-020: SubWord SHALL use 4 forward S-boxes and InvSubBytes SHALL use 16 inverse S-boxes, all combinational.
- REQ-021: All GF(2^8) multiplies SHALL use polynomial 0x11b; InvMixColumns SHALL use coefficients 0e, 0b, 0d, 09.
- REQ-022: Latency: with ld sampled at edge E0, done SHALL be high for exactly the cycle following edge E21.
  - Edges E1..E10 perform KEXP.
  - Edge E11 performs the initial AddRoundKey.
  - Edges E12..E21 perform rounds 9..0.
- REQ-023: text_out SHALL be updated at E21 and SHALL hold its value until the next completed operation or reset.
- REQ-024: ld while busy=1 SHALL be ignored; no restart and no corruption of the operation in flight.
- REQ-025: ld in the cycle done=1 SHALL be accepted, because the FSM is in IDLE; done SHALL still deassert on the next edge.
- REQ-026: key and text_in SHALL be sampled only at the ld edge; later changes SHALL have no effect on the result.
- REQ-027: busy SHALL be 1 from the edge after ld acceptance through edge E21, and 0 in IDLE.

Reset
- REQ-028: When rst=1 at a rising edge, the block SHALL:
  - set the FSM to IDLE;
  - clear done, busy, text_out, the state register, the round-key register and rcnt to 0.
- REQ-029: rst SHALL override ld in the same cycle.
- REQ-030: rst asserted mid-KEXP or mid-DEC SHALL abort the operation, with no done pulse for it.
- REQ-031: The first ld after rst deasserts SHALL be accepted normally.

Verification
- REQ-032: FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, text_in 69c4e0d86a7b0430d8cdb78070b4c55a, ld pulse -> at E21 done=1 for one cycle and text_out = 00112233445566778899aabbccddeeff.
- REQ-033: FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, text_in 3925841d02dc09fbdc118597196a0b32 -> text_out = 3243f6a8885a308d313198a2e0370734 at E21.
- REQ-034: Busy-ignore: during the C.1 run, pulse ld at E5 with a different key and text -> C.1 result at E21 and exactly one done pulse.
- REQ-035: Abort: rst at E15 of a run -> done never pulses and text_out = 0; a new ld after reset produces a correct result 21 edges later.
- REQ-036: Back-to-back: ld held high through the done cycle -> the second operation starts at the done edge, and its done follows 21 edges later with the correct result.
- REQ-037: Loopback: random key and plaintext through the team's aes encryptor, then this block -> text_out equals the original plaintext, for at least 1000 vectors.
